// File: rtl/rv_iopmp_reg_bridge.sv
// rv_iopmp_reg_bridge
// Bridges a valid/ready request/response bus onto a bank of word-wide
// register slices. Each access goes through three phases.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | ready for a request; the request is captured on handshake
//   ST_ACCESS | single cycle: decode, we/re pulse, write merge, read capture
//   ST_RESP   | response held stable until rsp_ready_i
//
// Only one transaction is in flight at a time. Partial writes are turned
// into full-word writes by merging the strobed bytes with the current
// slice value, so slices only ever see whole words on reg_wd_o.
module rv_iopmp_reg_bridge #(
  parameter int DW       = 32,
  parameter int AW       = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AW-1:0]          req_addr_i,
  input  logic                   req_write_i,
  input  logic [DW-1:0]          req_wdata_i,
  input  logic [DW/8-1:0]        req_wstrb_i,

  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DW-1:0]          rsp_rdata_o,
  output logic                   rsp_error_o,

  output logic [NUM_REGS-1:0]    reg_we_o,
  output logic [NUM_REGS-1:0]    reg_re_o,
  output logic [DW-1:0]          reg_wd_o,
  input  logic [NUM_REGS*DW-1:0] reg_qs_i
);

  localparam int SW = DW / 8;
  localparam int IW = AW - 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t r_state;

  logic [AW-1:0] r_addr;
  logic          r_write;
  logic [DW-1:0] r_wdata;
  logic [SW-1:0] r_wstrb;

  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_error;

  logic [IW-1:0]       w_idx;
  logic                w_err;
  logic [DW-1:0]       w_qs;
  logic [NUM_REGS-1:0] w_onehot;
  logic [DW-1:0]       w_merge;
  logic                w_in_access;
  logic                w_we_en;
  logic                w_re_en;

  // Address decode of the captured request: word index plus error flag.
  // An out-of-range index must never select a slice, so the error term
  // compares against the slice count rather than relying on index width.
  assign w_idx = r_addr[AW-1:2];
  assign w_err = (r_addr[1:0] != 2'b00) || (32'(w_idx) >= NUM_REGS);

  // Slice selection: read value of the addressed slice and its one-hot.
  // An index with no matching slice yields zero data and no select bit.
  always_comb begin
    w_qs     = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_idx == IW'(i)) begin
        w_qs        = reg_qs_i[i*DW +: DW];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Byte merge: strobed bytes from the request, the rest from the slice.
  always_comb begin
    w_merge = '0;
    for (int b = 0; b < SW; b++) begin
      w_merge[b*8 +: 8] = r_wstrb[b] ? r_wdata[b*8 +: 8] : w_qs[b*8 +: 8];
    end
  end

  // A reset landing in the access cycle suppresses the slice strobes so a
  // dropped transaction cannot leave a half-applied write behind.
  assign w_in_access = (r_state == ST_ACCESS) && !rst_i;
  assign w_we_en     = w_in_access &&  r_write && !w_err && (r_wstrb != '0);
  assign w_re_en     = w_in_access && !r_write && !w_err;

  assign reg_we_o = w_we_en ? w_onehot : '0;
  assign reg_re_o = w_re_en ? w_onehot : '0;
  assign reg_wd_o = w_in_access ? w_merge : '0;

  assign req_ready_o = (r_state == ST_IDLE) && !rst_i;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_error_o = r_rsp_error;

  // Transaction FSM: capture on handshake, one access cycle, then hold
  // the registered response until the consumer takes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid_i) begin
            r_addr  <= req_addr_i;
            r_write <= req_write_i;
            r_wdata <= req_wdata_i;
            r_wstrb <= req_wstrb_i;
            r_state <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_rsp_valid <= 1'b1;
          r_rsp_error <= w_err;
          r_rsp_rdata <= (!r_write && !w_err) ? w_qs : '0;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_error <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
